one_pulse_press_gen: RTL and testbench
======================================

ONE_PULSE_PRESS_GEN -- requirements
Module: one_pulse_press_gen

Interface
Parameters:
REQ-001 The block SHALL have parameter BOUNCE_CYC, default 4, meaning the number of alternating chatter cycles emitted at the start of each press when bounce is enabled (even, 2..14).
Ports (name  direction  width  meaning):
REQ-002 The block SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-004 The block SHALL have port start  input  1  request to begin one press sequence; sampled on the clk rising edge.
REQ-005 The block SHALL have port press_len  input  8  number of steady-high cycles per press; value 0 SHALL be treated as 1.
REQ-006 The block SHALL have port gap_len  input  8  number of low cycles between consecutive presses; value 0 SHALL be treated as 1.
REQ-007 The block SHALL have port repeat_n  input  4  number of presses in the sequence; value 0 SHALL be treated as 1.
REQ-008 The block SHALL have port bounce_en  input  1  when 1, each press begins with BOUNCE_CYC chatter cycles.
REQ-009 The block SHALL have port trig_out  output  1  generated button level, registered, suitable for driving a one-pulse or long-press detector input.
REQ-010 The block SHALL have port busy  output  1  high from the cycle after start is accepted until done is asserted.
REQ-011 The block SHALL have port done  output  1  single-cycle pulse marking the end of a sequence.

Function
REQ-012 The FSM SHALL have states IDLE, BOUNCE, PRESS, GAP and FIN.
REQ-013 In IDLE, start=1 SHALL be accepted and press_len, gap_len, repeat_n and bounce_en SHALL be latched in the same cycle; later input changes SHALL have no effect on the running sequence.
REQ-014 While busy=1, start SHALL be ignored, with no queuing.
REQ-015 After acceptance at edge t, trig_out SHALL first be high in cycle t+1.
REQ-016 On acceptance, the next state SHALL be BOUNCE if bounce_en=1, else PRESS.
REQ-017 BOUNCE SHALL drive trig_out in the pattern 1,0,1,0,... for exactly BOUNCE_CYC cycles, then go to PRESS.
REQ-018 PRESS SHALL hold trig_out=1 for exactly the effective press_len cycles.
REQ-019 At the end of PRESS, if presses remain, the next state SHALL be GAP, which holds trig_out=0 for exactly the effective gap_len cycles and then returns to BOUNCE or PRESS according to the latched bounce_en.
REQ-020 At the end of the final PRESS, the next state SHALL be FIN with no trailing gap.
REQ-021 FIN SHALL last one cycle with trig_out=0, done=1 and busy=0, then go to IDLE.
REQ-022 A start presented in the FIN cycle SHALL be ignored; a start in the following cycle (IDLE) SHALL be accepted.
REQ-023 The cycle counter SHALL be 8-bit and the press counter 4-bit.
REQ-024 No counter SHALL wrap: press_len=255 SHALL yield exactly 255 high cycles, and repeat_n=15 SHALL yield exactly 15 presses.
REQ-025 Total sequence length SHALL be N*(B+P) + (N-1)*G cycles, where N, P and G are the effective repeat_n, press_len and gap_len, and B is BOUNCE_CYC if the latched bounce_en=1, else 0.

Reset
REQ-026 rst_n=0 SHALL, asynchronously and regardless of state, force the FSM to IDLE, clear all counters and latched operands, and drive trig_out=0, busy=0 and done=0.
REQ-027 A reset asserted mid-sequence SHALL abort the sequence with no done pulse.
REQ-028 After rst_n deasserts, the first start SHALL be accepted normally.

Structure
REQ-029 The state encoding constants (IDLE..FIN) and the BOUNCE_CYC default SHALL reside in a shared package or header used by the block and its bench.
REQ-030 One sub-module SHALL be used: press_cycle_counter, a loadable 8-bit down-counter with a zero flag, instantiated once for the BOUNCE, PRESS and GAP timing.
REQ-031 All outputs SHALL be registered, with no combinational path from any input to any output.

Verification
REQ-032 Scenario: start with press_len=3, repeat_n=1, bounce_en=0 -> trig_out=1 in cycles t+1..t+3, done=1 in t+4, busy=1 in t+1..t+3.
REQ-033 Scenario: press_len=2, gap_len=2, repeat_n=3 -> trig_out pattern 1,1,0,0,1,1,0,0,1,1, then a done pulse.
REQ-034 Scenario: bounce_en=1, BOUNCE_CYC=4, press_len=2 -> trig_out pattern 1,0,1,0,1,1, then done.
REQ-035 Scenario: press_len=0, gap_len=0, repeat_n=0 -> a single high cycle, then done one cycle later.
REQ-036 Scenario: start pulsed again mid-sequence, and again in the FIN cycle -> both ignored; a start one cycle after FIN -> accepted.
REQ-037 Scenario: rst_n pulsed low during the GAP state of a 3-press sequence -> trig_out, busy and done all 0 immediately, and no done pulse follows.

Source files
------------

// File: rtl/one_pulse_press_gen_pkg.sv
// Shared types and constants for the button-press stimulus generator.
package one_pulse_press_gen_pkg;

    localparam int unsigned LEN_W          = 8;
    localparam int unsigned REP_W          = 4;
    localparam int unsigned BOUNCE_CYC_DEF = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BOUNCE = 3'd1,
        PRESS  = 3'd2,
        GAP    = 3'd3,
        FIN    = 3'd4
    } state_t;

    // Operands captured when a sequence is accepted, already zero-corrected
    typedef struct packed {
        logic [LEN_W-1:0] press_len;
        logic [LEN_W-1:0] gap_len;
        logic             bounce_en;
    } seq_cfg_t;

    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] v);
        return (v == '0) ? LEN_W'(1) : v;
    endfunction

    function automatic logic [REP_W-1:0] eff_rep(input logic [REP_W-1:0] v);
        return (v == '0) ? REP_W'(1) : v;
    endfunction

endpackage

// File: rtl/one_pulse_press_gen_counter.sv
// Loadable down-counter timing each BOUNCE/PRESS/GAP phase; stops at zero.
module press_cycle_counter
    import one_pulse_press_gen_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             dec,
    output logic [LEN_W-1:0] count,
    output logic             zero_c
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - LEN_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/one_pulse_press_gen.sv
// Generates a programmable sequence of button presses (optional chatter) on trig_out.
module one_pulse_press_gen
    import one_pulse_press_gen_pkg::*;
#(
    parameter int unsigned BOUNCE_CYC = BOUNCE_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] press_len,
    input  logic [LEN_W-1:0] gap_len,
    input  logic [REP_W-1:0] repeat_n,
    input  logic             bounce_en,
    output logic             trig_out,
    output logic             busy,
    output logic             done
);

    localparam logic [LEN_W-1:0] BOUNCE_LOAD = LEN_W'(BOUNCE_CYC - 1);

    state_t           state, state_nxt;
    seq_cfg_t         cfg_q;
    logic             cfg_ld_c;
    logic [REP_W-1:0] press_rem, press_rem_nxt;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [LEN_W-1:0] cnt_load_val, cnt;
    logic             trig_nxt, busy_nxt, done_nxt;

    press_cycle_counter u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero_c   (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, counter control, and the output values for the coming cycle
    always_comb begin
        state_nxt     = state;
        cfg_ld_c      = 1'b0;
        press_rem_nxt = press_rem;
        cnt_load      = 1'b0;
        cnt_load_val  = '0;
        cnt_dec       = 1'b0;
        trig_nxt      = 1'b0;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    cfg_ld_c      = 1'b1;
                    press_rem_nxt = eff_rep(repeat_n);
                    cnt_load      = 1'b1;
                    if (bounce_en) begin
                        state_nxt    = BOUNCE;
                        cnt_load_val = BOUNCE_LOAD;
                    end else begin
                        state_nxt    = PRESS;
                        cnt_load_val = eff_len(press_len) - LEN_W'(1);
                    end
                end
            end
            BOUNCE: begin
                if (cnt_zero) begin
                    state_nxt    = PRESS;
                    cnt_load     = 1'b1;
                    cnt_load_val = cfg_q.press_len - LEN_W'(1);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            PRESS: begin
                if (cnt_zero) begin
                    press_rem_nxt = press_rem - REP_W'(1);
                    if (press_rem == REP_W'(1)) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt    = GAP;
                        cnt_load     = 1'b1;
                        cnt_load_val = cfg_q.gap_len - LEN_W'(1);
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    if (cfg_q.bounce_en) begin
                        state_nxt    = BOUNCE;
                        cnt_load_val = BOUNCE_LOAD;
                    end else begin
                        state_nxt    = PRESS;
                        cnt_load_val = cfg_q.press_len - LEN_W'(1);
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Chatter starts high on entry and toggles every cycle
        case (state_nxt)
            BOUNCE:  trig_nxt = (state != BOUNCE) ? 1'b1 : ~trig_out;
            PRESS:   trig_nxt = 1'b1;
            default: trig_nxt = 1'b0;
        endcase
        busy_nxt = (state_nxt == BOUNCE) || (state_nxt == PRESS) || (state_nxt == GAP);
        done_nxt = (state_nxt == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q     <= '0;
            press_rem <= '0;
        end else begin
            press_rem <= press_rem_nxt;
            if (cfg_ld_c) begin
                cfg_q.press_len <= eff_len(press_len);
                cfg_q.gap_len   <= eff_len(gap_len);
                cfg_q.bounce_en <= bounce_en;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_out <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            trig_out <= trig_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_one_pulse_press_gen.sv
// Scoreboard bench: expected {trig_out,busy,done} per cycle queued at start, compared each cycle.
module tb_one_pulse_press_gen;
    import one_pulse_press_gen_pkg::*;

    localparam int unsigned BC = BOUNCE_CYC_DEF;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] press_len;
    logic [7:0] gap_len;
    logic [3:0] repeat_n;
    logic       bounce_en;
    logic       trig_out, busy, done;

    logic [2:0] exp_q[$];
    int         checks = 0;
    int         passed = 0;

    one_pulse_press_gen #(.BOUNCE_CYC(BC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .press_len (press_len),
        .gap_len   (gap_len),
        .repeat_n  (repeat_n),
        .bounce_en (bounce_en),
        .trig_out  (trig_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Drive a start (just after a falling edge) and queue the expected trace, FIN and one idle cycle
    task automatic launch(input int p, input int g, input int n, input bit b);
        int pe, ge, ne;
        press_len = 8'(p);
        gap_len   = 8'(g);
        repeat_n  = 4'(n);
        bounce_en = b;
        start     = 1'b1;
        pe = (p == 0) ? 1 : p;
        ge = (g == 0) ? 1 : g;
        ne = (n == 0) ? 1 : n;
        for (int k = 0; k < ne; k++) begin
            if (b) begin
                for (int j = 0; j < int'(BC); j++) exp_q.push_back({(j % 2 == 0), 1'b1, 1'b0});
            end
            for (int j = 0; j < pe; j++) exp_q.push_back(3'b110);
            if (k < ne - 1) begin
                for (int j = 0; j < ge; j++) exp_q.push_back(3'b010);
            end
        end
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b000);
    endtask

    task automatic test_reset();
        checks++;
        if ({trig_out, busy, done} !== 3'b000)
            $display("FAIL reset_state: got %b exp 000", {trig_out, busy, done});
        else passed++;
    endtask

    task automatic test_single_press();
        logic [2:0] e;
        int i = 0;
        launch(3, 1, 1, 0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({trig_out, busy, done} !== e)
                $display("FAIL single_press cyc %0d: got %b exp %b", i, {trig_out, busy, done}, e);
            else passed++;
            start = 1'b0;
            i++;
        end
    endtask

    task automatic test_multi_press();
        logic [2:0] e;
        int i = 0;
        launch(2, 2, 3, 0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({trig_out, busy, done} !== e)
                $display("FAIL multi_press cyc %0d: got %b exp %b", i, {trig_out, busy, done}, e);
            else passed++;
            start = 1'b0;
            i++;
        end
    endtask

    task automatic test_bounce();
        logic [2:0] e;
        int i = 0;
        launch(2, 3, 1, 1);
        launch(2, 3, 2, 1);
        exp_q.delete();
        launch(2, 3, 2, 1);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({trig_out, busy, done} !== e)
                $display("FAIL bounce cyc %0d: got %b exp %b", i, {trig_out, busy, done}, e);
            else passed++;
            start = 1'b0;
            i++;
        end
    endtask

    task automatic test_zero_operands();
        logic [2:0] e;
        int i = 0;
        launch(0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({trig_out, busy, done} !== e)
                $display("FAIL zero_operands cyc %0d: got %b exp %b", i, {trig_out, busy, done}, e);
            else passed++;
            start = 1'b0;
            i++;
        end
    endtask

    task automatic test_max_counts();
        logic [2:0] e;
        int i = 0;
        launch(255, 1, 1, 0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({trig_out, busy, done} !== e)
                $display("FAIL max_press_len cyc %0d: got %b exp %b", i, {trig_out, busy, done}, e);
            else passed++;
            start = 1'b0;
            i++;
        end
        i = 0;
        launch(1, 1, 15, 1);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({trig_out, busy, done} !== e)
                $display("FAIL max_repeat cyc %0d: got %b exp %b", i, {trig_out, busy, done}, e);
            else passed++;
            start = 1'b0;
            i++;
        end
    endtask

    // Starts mid-sequence (with changed operands) and in FIN are ignored; start right after FIN runs
    task automatic test_back_to_back();
        logic [2:0] e;
        int i = 0;
        int fin_idx;
        launch(2, 2, 2, 0);
        fin_idx = exp_q.size() - 2;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({trig_out, busy, done} !== e)
                $display("FAIL ignore_start cyc %0d: got %b exp %b", i, {trig_out, busy, done}, e);
            else passed++;
            start = (i == 2) || (i == fin_idx);
            if (i == 2) begin
                press_len = 8'd9;
                gap_len   = 8'd50;
                repeat_n  = 4'd7;
                bounce_en = 1'b1;
            end
            i++;
        end
        i = 0;
        launch(1, 4, 2, 0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({trig_out, busy, done} !== e)
                $display("FAIL start_after_fin cyc %0d: got %b exp %b", i, {trig_out, busy, done}, e);
            else passed++;
            start = 1'b0;
            i++;
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] e;
        bit         stray;
        launch(2, 3, 3, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({trig_out, busy, done} !== e)
                $display("FAIL pre_reset cyc %0d: got %b exp %b", i, {trig_out, busy, done}, e);
            else passed++;
            start = 1'b0;
        end
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({trig_out, busy, done} !== 3'b000)
            $display("FAIL async_reset: got %b exp 000", {trig_out, busy, done});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || busy || trig_out) stray = 1'b1;
        end
        checks++;
        if (stray !== 1'b0)
            $display("FAIL no_done_after_reset: got activity %b exp 0", stray);
        else passed++;
    endtask

    task automatic test_after_reset();
        logic [2:0] e;
        int i = 0;
        launch(4, 1, 1, 1);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({trig_out, busy, done} !== e)
                $display("FAIL after_reset cyc %0d: got %b exp %b", i, {trig_out, busy, done}, e);
            else passed++;
            start = 1'b0;
            i++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        press_len = '0;
        gap_len   = '0;
        repeat_n  = '0;
        bounce_en = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_single_press();
        test_multi_press();
        test_bounce();
        test_zero_operands();
        test_max_counts();
        test_back_to_back();
        test_reset_mid();
        test_after_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
